// File: rtl/maze_pkg.sv
// Shared types and constants for the maze game controller.
// State encodings, move directions, grid and wall-vector sizes.
package maze_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GEN_START = 3'd1,
    GEN_WAIT  = 3'd2,
    PLAY      = 3'd3,
    WIN       = 3'd4,
    LOSE      = 3'd5
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int GRID_W = 10;
  localparam int GRID_H = 15;

  localparam int H_WALL_BITS = 160;
  localparam int V_WALL_BITS = 165;

  localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX = 4'(GRID_H - 1);

endpackage

// File: rtl/maze_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing every cycle.
// A zero seed is replaced by 8'h01 so the register never locks up.
module maze_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

  always_ff @(posedge clk) begin
    if (rst) r_q <= INIT;
    else     r_q <= {r_q[6:0], w_fb};
  end

  assign q = r_q;

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze level sequencer: drives the generator, then runs one play session.
// Optional play time budget is enabled with MAZE_CTRL_TIMER_EN.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
`ifdef MAZE_CTRL_TIMER_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   move_valid,
  input  logic [1:0]             move_dir,
  output logic                   move_ready,
  output logic                   gen_rst,
  output logic [7:0]             gen_rnd,
  input  logic                   gen_busy,
  input  logic [H_WALL_BITS-1:0] h_walls,
  input  logic [V_WALL_BITS-1:0] v_walls,
  output logic [3:0]             player_x,
  output logic [3:0]             player_y,
  output logic [7:0]             level,
  output logic [2:0]             state,
  output logic                   bump,
  output logic                   win,
  output logic                   lose
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_x;
  logic [3:0] r_y;
  logic [7:0] r_level;
  logic       r_bump;
  logic       r_win;

  logic       w_acc;
  logic       w_enter;
  logic [3:0] w_tx;
  logic [3:0] w_ty;
  logic [7:0] w_hidx;
  logic [7:0] w_vidx;
  logic       w_off;
  logic       w_wall;
  logic       w_blk;
  logic       w_win_mv;
  logic       w_tmo;

  maze_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .q  (gen_rnd)
  );

  assign w_acc   = move_valid && (r_state == PLAY);
  assign w_enter = (r_state == GEN_WAIT) && !gen_busy;

  // Off-grid test stands alone so wall bits past the edge are ignored.
  always_comb begin
    w_tx   = r_x;
    w_ty   = r_y;
    w_hidx = 8'(r_y) * 8'd10 + 8'(r_x);
    w_vidx = 8'(r_y) * 8'd11 + 8'(r_x);
    w_off  = 1'b0;
    w_wall = 1'b0;
    unique case (move_dir)
      DIR_UP: begin
        w_off  = (r_y == 4'd0);
        w_wall = h_walls[w_hidx];
        w_ty   = r_y - 4'd1;
      end
      DIR_RIGHT: begin
        w_off  = (r_x == X_MAX);
        w_wall = v_walls[w_vidx + 8'd1];
        w_tx   = r_x + 4'd1;
      end
      DIR_DOWN: begin
        w_off  = (r_y == Y_MAX);
        w_wall = h_walls[w_hidx + 8'd10];
        w_ty   = r_y + 4'd1;
      end
      default: begin
        w_off  = (r_x == 4'd0);
        w_wall = v_walls[w_vidx];
        w_tx   = r_x - 4'd1;
      end
    endcase
  end

  assign w_blk    = w_off || w_wall;
  assign w_win_mv = w_acc && !w_blk
                 && (w_tx == X_MAX)
                 && (w_ty == Y_MAX);

`ifdef MAZE_CTRL_TIMER_EN
  logic [19:0] r_tmr;
  logic        r_lose;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr <= '0;
    end else if (w_enter) begin
      r_tmr <= 20'(TIMEOUT_CYCLES);
    end else if (r_state == PLAY && r_tmr != '0) begin
      r_tmr <= r_tmr - 20'd1;
    end
  end

  // Expires on the edge where the counter reaches zero.
  assign w_tmo = (r_state == PLAY) && (r_tmr <= 20'd1);

  always_ff @(posedge clk) begin
    if (rst) r_lose <= 1'b0;
    else     r_lose <= w_tmo && !w_win_mv;
  end

  assign lose = r_lose;
`else
  assign w_tmo = 1'b0;
  assign lose  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (start) w_next = GEN_START;
      GEN_START: w_next = GEN_WAIT;
      GEN_WAIT:  if (!gen_busy) w_next = PLAY;
      PLAY: begin
        if (w_win_mv)   w_next = WIN;
        else if (w_tmo) w_next = LOSE;
      end
      WIN:       if (start) w_next = GEN_START;
      LOSE:      if (start) w_next = GEN_START;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    gen_rst    = rst
              || (r_state == IDLE)
              || (r_state == GEN_START);
    move_ready = (r_state == PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_level <= '0;
      r_bump  <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_bump <= w_acc && w_blk;
      r_win  <= w_win_mv;
      if (w_enter) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_acc && !w_blk) begin
        r_x <= w_tx;
        r_y <= w_ty;
      end
      if (r_state == WIN && start && r_level != 8'hFF)
        r_level <= r_level + 8'd1;
    end
  end

  assign player_x = r_x;
  assign player_y = r_y;
  assign level    = r_level;
  assign state    = r_state;
  assign bump     = r_bump;
  assign win      = r_win;

endmodule
